rgb_pwm_fader: RTL and testbench

//  Downstream output stage for the rainbow colour generator: accepts 24-bit RGB targets over a

---
 rtl/rgb_pwm_fader.sv | 116 +++++++++++
 tb/tb_rgb_pwm_fader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// RGB output stage: accepts 24-bit colour targets, fades each channel linearly toward them,
// and drives three LED pins with period-aligned (glitch-free) PWM.
//
// state | meaning
// IDLE  | no fade running; in_ready high, next valid target is latched
// FADE  | stepping cur toward tgt once every FADE_DIV cycles; in_valid ignored
module rgb_pwm_fader #(
   parameter int PWM_BITS   = 8,
   parameter int FADE_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_rgb,
   output logic        busy,
   output logic [2:0]  led
);

   localparam int                   PRESC_W    = $clog2(FADE_DIV);
   localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0]  PWM_LAST   = '1;

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } state_t;

   state_t                      state_q, state_d;
   logic [PRESC_W-1:0]          presc_q, presc_d;
   logic [2:0][PWM_BITS-1:0]    cur_q, cur_d;
   logic [2:0][PWM_BITS-1:0]    tgt_q, tgt_d;
   logic [2:0][PWM_BITS-1:0]    duty_q;
   logic [2:0][PWM_BITS-1:0]    tgt_in;
   logic [PWM_BITS-1:0]         pwm_q;
   logic [2:0]                  lit;

   // Channel index matches the led bit: 2=R, 1=G, 0=B; narrow PWM keeps the byte MSBs
   assign tgt_in[2] = in_rgb[23 -: PWM_BITS];
   assign tgt_in[1] = in_rgb[15 -: PWM_BITS];
   assign tgt_in[0] = in_rgb[7  -: PWM_BITS];

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q == FADE);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tgt_d   = tgt_q;
      cur_d   = cur_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               tgt_d   = tgt_in;
               presc_d = '0;
               state_d = FADE;
            end
         end
         FADE: begin
            if (cur_q == tgt_q) begin
               state_d = IDLE;
            end else if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               for (int i = 0; i < 3; i++) begin
                  if (cur_q[i] < tgt_q[i]) begin
                     cur_d[i] = cur_q[i] + 1'b1;
                  end else if (cur_q[i] > tgt_q[i]) begin
                     cur_d[i] = cur_q[i] - 1'b1;
                  end
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         cur_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      lit = '0;
      for (int i = 0; i < 3; i++) begin
         lit[i] = (pwm_q < duty_q[i]);
      end
   end

   // Duty only reloads on the last count so every period uses one consistent compare value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q  <= '0;
         duty_q <= '0;
         led    <= {3{ACTIVE_LOW}};
      end else begin
         pwm_q <= pwm_q + 1'b1;
         if (pwm_q == PWM_LAST) begin
            duty_q <= cur_q;
         end
         led <= lit ^ {3{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: per-cycle comparison against a time-based fade/PWM model,
// a table of targets with expected busy durations, and hand sequences for the corner cases.
module tb_rgb_pwm_fader;

   localparam int F   = 4;
   localparam int PER = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] in_rgb = '0;
   logic        in_ready, busy;
   logic [2:0]  led;

   always #5 clk = ~clk;

   rgb_pwm_fader #(.PWM_BITS(8), .FADE_DIV(F), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rgb(in_rgb), .busy(busy), .led(led)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
   endtask

   // Model: cur is a closed-form function of time since acceptance; index 0=R,1=G,2=B
   int k;
   int m_start[3];
   int m_tgt[3];
   int m_acc;
   bit m_fading;
   int m_duty[3];

   function automatic int cur_at(input int ch, input int t);
      int d, ad, s;
      if (!m_fading) return m_start[ch];
      d  = m_tgt[ch] - m_start[ch];
      ad = (d < 0) ? -d : d;
      s  = (t - m_acc) / F;
      if (s > ad) s = ad;
      return (d < 0) ? m_start[ch] - s : m_start[ch] + s;
   endfunction

   function automatic bit busy_at(input int t);
      int md, d;
      md = 0;
      for (int ch = 0; ch < 3; ch++) begin
         d = m_tgt[ch] - m_start[ch];
         if (d < 0) d = -d;
         if (d > md) md = d;
      end
      return m_fading && ((t - m_acc) <= md * F);
   endfunction

   task automatic model_reset();
      k = 0;
      m_acc = 0;
      m_fading = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         m_start[ch] = 0;
         m_tgt[ch]   = 0;
         m_duty[ch]  = 0;
      end
   endtask

   task automatic tick();
      int kp, pwm_p;
      int cur_p[3];
      bit busy_p, bn;
      logic [2:0] exp_led;
      @(posedge clk);
      kp     = k;
      pwm_p  = kp % PER;
      busy_p = busy_at(kp);
      for (int ch = 0; ch < 3; ch++) begin
         cur_p[ch]      = cur_at(ch, kp);
         exp_led[2-ch]  = !(pwm_p < m_duty[ch]);
      end
      if (pwm_p == PER - 1)
         for (int ch = 0; ch < 3; ch++) m_duty[ch] = cur_p[ch];
      if (in_valid && !busy_p) begin
         for (int ch = 0; ch < 3; ch++) m_start[ch] = cur_p[ch];
         m_tgt[0] = int'(in_rgb[23:16]);
         m_tgt[1] = int'(in_rgb[15:8]);
         m_tgt[2] = int'(in_rgb[7:0]);
         m_acc    = kp + 1;
         m_fading = 1'b1;
      end
      k = kp + 1;
      #1;
      bn = busy_at(k);
      check("cycle{led,busy,ready}", int'({led, busy, in_ready}), int'({exp_led, bn, !bn}));
   endtask

   // Presents rgb until accepted; optionally then counts cycles with busy high
   task automatic send(input logic [23:0] rgb, input bit count, output int waited, output int bcyc);
      in_rgb   = rgb;
      in_valid = 1'b1;
      waited   = 0;
      bcyc     = 0;
      while (!in_ready && waited < 3000) begin
         tick();
         waited++;
      end
      if (waited >= 3000) check("accept_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      if (count) begin
         while (busy && bcyc < 3000) begin
            bcyc++;
            tick();
         end
         if (bcyc >= 3000) check("busy_timeout", 0, 1);
      end
   endtask

   // Counts low cycles of one led over a period aligned to pwm_cnt==0
   task automatic measure(input int bitn, input int duty, output int lows, output int misplaced);
      int g;
      bit low;
      lows = 0;
      misplaced = 0;
      g = 0;
      while ((k % PER) != 0 && g < PER) begin
         tick();
         g++;
      end
      for (int j = 0; j < PER; j++) begin
         tick();
         low = (led[bitn] == 1'b0);
         if (low) lows++;
         if (low != (j < duty)) misplaced++;
      end
   endtask

   typedef struct {
      logic [23:0] rgb;
      int          exp_busy;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   w, b, lows, mis, dark;

      vecs[0] = '{24'hFF_00_80, 1021};
      vecs[1] = '{24'hFF_00_80, 1};
      vecs[2] = '{24'h40_10_A0, 765};
      vecs[3] = '{24'h00_00_00, 641};
      vecs[4] = '{24'h00_00_01, 5};
      vecs[5] = '{24'h40_00_00, 257};
      vecs[6] = '{24'hFF_00_00, 765};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_led", int'(led), 7);
      check("reset_busy", int'(busy), 0);
      check("reset_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      check("release_led", int'(led), 7);

      dark = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         if (led != 3'b111) dark++;
      end
      check("idle_dark_cycles_lit", dark, 0);

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].rgb, 1'b1, w, b);
         check($sformatf("vec%0d_busy_cycles", i), b, vecs[i].exp_busy);
         if (i == 5) begin
            measure(2, 64, lows, mis);
            check("r40_low_count", lows, 64);
            check("r40_low_misplaced", mis, 0);
            measure(1, 0, lows, mis);
            check("g00_low_count", lows, 0);
         end
         if (i == 6) begin
            measure(2, 255, lows, mis);
            check("rff_low_count", lows, 255);
            check("rff_low_misplaced", mis, 0);
         end
      end

      // Target presented during a fade must wait for the first IDLE cycle
      send(24'h10_20_30, 1'b0, w, b);
      check("midfade_first_accept_wait", w, 0);
      send(24'h00_FF_00, 1'b1, w, b);
      check("midfade_wait_cycles", w, 957);
      check("midfade_second_busy", b, 893);

      for (int i = 0; i < 4000; i++) begin
         in_valid = ($urandom_range(0, 63) == 0);
         in_rgb   = 24'($urandom);
         tick();
      end
      in_valid = 1'b0;

      // Reset in the middle of a fade
      send(24'hFF_FF_FF, 1'b0, w, b);
      repeat (300) tick();
      rst_n = 1'b0;
      #1;
      check("midreset_led", int'(led), 7);
      check("midreset_busy", int'(busy), 0);
      check("midreset_ready", int'(in_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      dark = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         if (led != 3'b111) dark++;
      end
      check("post_reset_dark_cycles_lit", dark, 0);
      check("post_reset_ready", int'(in_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
